vcache_stat_counter_bank: RTL and testbench

Synthesizable, parametrised event-counter bank for the vcache array. One instance observes `num_banks_p` vcache output channels and keeps saturating per-bank counters for loads, stores, load misses, store misses, atomics and output-stall cycles. On request it snapshots every counter plus a tag into shadow registers and drains them as a valid/yumi record stream. The stream can feed a host-readable FIFO or a testbench logger, so stats capture no longer depends on simulation-only file I/O.

---
 rtl/vcache_stat_counter_bank.sv | 152 +++++++++++++++
 tb/tb_vcache_stat_counter_bank.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcache_stat_counter_bank.sv
// Per-bank saturating event counters for the vcache output channels, with a
// snapshot/shadow copy that is drained as a bank-major valid/yumi record stream.
module vcache_stat_counter_bank #(
  parameter int num_banks_p = 8,
  parameter int ctr_width_p = 32,
  parameter int tag_width_p = 32,
  localparam int bank_id_width_lp = (num_banks_p > 1) ? $clog2(num_banks_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [num_banks_p-1:0]      v_i,
  input  logic [num_banks_p-1:0]      yumi_i,
  input  logic [num_banks_p-1:0]      miss_i,
  input  logic [num_banks_p-1:0]      ld_op_i,
  input  logic [num_banks_p-1:0]      st_op_i,
  input  logic [num_banks_p-1:0]      atomic_op_i,
  input  logic                        clear_i,
  input  logic                        snap_v_i,
  input  logic [tag_width_p-1:0]      snap_tag_i,
  output logic                        snap_ready_o,
  output logic                        out_v_o,
  output logic [bank_id_width_lp-1:0] out_bank_o,
  output logic [2:0]                  out_event_o,
  output logic [ctr_width_p-1:0]      out_count_o,
  output logic [tag_width_p-1:0]      out_tag_o,
  input  logic                        out_yumi_i
);

  localparam logic [bank_id_width_lp-1:0] last_bank_lp  = bank_id_width_lp'(num_banks_p - 1);
  localparam logic [2:0]                  last_event_lp = 3'd5;
  localparam logic [ctr_width_p-1:0]      one_lp        = ctr_width_p'(1);

  typedef enum logic {
    e_idle,
    e_drain
  } state_e;

  state_e state_r, state_n;

  logic [ctr_width_p-1:0]      live_r   [num_banks_p][6];
  logic [ctr_width_p-1:0]      shadow_r [num_banks_p][6];
  logic [tag_width_p-1:0]      tag_r;
  logic [bank_id_width_lp-1:0] bank_r;
  logic [2:0]                  event_r;
  logic [5:0]                  inc      [num_banks_p];

  logic snap_accept;
  logic take;
  logic last_take;

  // Bit position in inc[b] equals the event id reported on out_event_o.
  always_comb begin
    for (int b = 0; b < num_banks_p; b++) begin
      inc[b]    = '0;
      inc[b][0] = v_i[b] & yumi_i[b] & ld_op_i[b];
      inc[b][1] = v_i[b] & yumi_i[b] & st_op_i[b];
      inc[b][2] = v_i[b] & yumi_i[b] & ld_op_i[b] & miss_i[b];
      inc[b][3] = v_i[b] & yumi_i[b] & st_op_i[b] & miss_i[b];
      inc[b][4] = v_i[b] & yumi_i[b] & atomic_op_i[b];
      inc[b][5] = v_i[b] & ~yumi_i[b];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    snap_accept  = 1'b0;
    take         = 1'b0;
    last_take    = 1'b0;
    snap_ready_o = 1'b0;
    out_v_o      = 1'b0;
    case (state_r)
      e_idle: begin
        snap_ready_o = 1'b1;
        if (snap_v_i) begin
          snap_accept = 1'b1;
          state_n     = e_drain;
        end
      end
      e_drain: begin
        out_v_o = 1'b1;
        if (out_yumi_i) begin
          take = 1'b1;
          if (bank_r == last_bank_lp && event_r == last_event_lp) begin
            last_take = 1'b1;
            state_n   = e_idle;
          end
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // Clear wins over a same-cycle increment; saturated counters simply hold.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int b = 0; b < num_banks_p; b++)
        for (int e = 0; e < 6; e++)
          live_r[b][e] <= '0;
    end else begin
      for (int b = 0; b < num_banks_p; b++)
        for (int e = 0; e < 6; e++)
          if (clear_i)
            live_r[b][e] <= '0;
          else if (inc[b][e] && (live_r[b][e] != '1))
            live_r[b][e] <= live_r[b][e] + one_lp;
    end
  end

  // The shadow copy takes the pre-edge live values, so a snapshot coinciding
  // with clear_i still captures the interval that just ended.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int b = 0; b < num_banks_p; b++)
        for (int e = 0; e < 6; e++)
          shadow_r[b][e] <= '0;
      tag_r   <= '0;
      bank_r  <= '0;
      event_r <= '0;
    end else if (snap_accept) begin
      for (int b = 0; b < num_banks_p; b++)
        for (int e = 0; e < 6; e++)
          shadow_r[b][e] <= live_r[b][e];
      tag_r   <= snap_tag_i;
      bank_r  <= '0;
      event_r <= '0;
    end else if (take) begin
      if (last_take) begin
        bank_r  <= '0;
        event_r <= '0;
      end else if (event_r == last_event_lp) begin
        bank_r  <= bank_r + bank_id_width_lp'(1);
        event_r <= '0;
      end else begin
        event_r <= event_r + 3'd1;
      end
    end
  end

  assign out_bank_o  = bank_r;
  assign out_event_o = event_r;
  assign out_count_o = shadow_r[bank_r][event_r];
  assign out_tag_o   = tag_r;

endmodule

// File: tb/tb_vcache_stat_counter_bank.sv
// Directed bench for vcache_stat_counter_bank: a default 8-bank instance plus a
// 2-bank, 4-bit-counter instance used for the saturation scenario.
module tb_vcache_stat_counter_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  v, yumi, miss, ld, st, at;
  logic        clear, snap_v, out_yumi;
  logic [31:0] snap_tag;
  logic        snap_ready, out_v;
  logic [2:0]  out_bank, out_event;
  logic [31:0] out_count, out_tag;

  logic [1:0]  s_v, s_yumi, s_miss, s_ld, s_st, s_at;
  logic        s_clear, s_snap_v, s_out_yumi;
  logic [7:0]  s_tag, s_out_tag;
  logic        s_ready, s_out_v;
  logic [0:0]  s_bank;
  logic [2:0]  s_event;
  logic [3:0]  s_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] rec_count [48];
  logic [31:0] rec_tag   [48];
  logic [31:0] exp_cnt   [48];

  always #5 clk = ~clk;

  vcache_stat_counter_bank dut (
    .clk_i(clk), .reset_i(rst), .v_i(v), .yumi_i(yumi), .miss_i(miss),
    .ld_op_i(ld), .st_op_i(st), .atomic_op_i(at), .clear_i(clear),
    .snap_v_i(snap_v), .snap_tag_i(snap_tag), .snap_ready_o(snap_ready),
    .out_v_o(out_v), .out_bank_o(out_bank), .out_event_o(out_event),
    .out_count_o(out_count), .out_tag_o(out_tag), .out_yumi_i(out_yumi)
  );

  vcache_stat_counter_bank #(.num_banks_p(2), .ctr_width_p(4), .tag_width_p(8)) dut_sat (
    .clk_i(clk), .reset_i(rst), .v_i(s_v), .yumi_i(s_yumi), .miss_i(s_miss),
    .ld_op_i(s_ld), .st_op_i(s_st), .atomic_op_i(s_at), .clear_i(s_clear),
    .snap_v_i(s_snap_v), .snap_tag_i(s_tag), .snap_ready_o(s_ready),
    .out_v_o(s_out_v), .out_bank_o(s_bank), .out_event_o(s_event),
    .out_count_o(s_count), .out_tag_o(s_out_tag), .out_yumi_i(s_out_yumi)
  );

  // Drive one bank's channel signals for a number of cycles, then idle them.
  task automatic applyStimulus(input int b, input bit vv, input bit yy, input bit l,
                               input bit s, input bit m, input bit a, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      v = '0; yumi = '0; ld = '0; st = '0; miss = '0; at = '0;
      v[b] = vv; yumi[b] = yy; ld[b] = l; st[b] = s; miss[b] = m; at[b] = a;
      @(posedge clk); #1;
    end
    v = '0; yumi = '0; ld = '0; st = '0; miss = '0; at = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic take_snapshot(input logic [31:0] tag, input bit with_clear);
    snap_v = 1'b1; snap_tag = tag; clear = with_clear;
    @(posedge clk); #1;
    snap_v = 1'b0; clear = 1'b0;
  endtask

  // Collects records from the main instance; reports ordering/hold violations.
  task automatic drain(input int yumi_pct, input int snap_at, output int n,
                       output int order_err, output int hold_err, output bit timeout);
    int cycles, eb, ee;
    bit held;
    logic [2:0]  hb, he;
    logic [31:0] hc, ht;
    n = 0; cycles = 0; eb = 0; ee = 0; held = 0; order_err = 0; hold_err = 0;
    hb = '0; he = '0; hc = '0; ht = '0;
    while (n < 48 && cycles < 2000) begin
      snap_v = (snap_at >= 0 && n == snap_at);
      snap_tag = snap_v ? 32'hFFFF : snap_tag;
      if (out_v) begin
        if (held && {out_bank, out_event, out_count, out_tag} !== {hb, he, hc, ht}) hold_err++;
        if (out_bank !== 3'(eb) || out_event !== 3'(ee)) order_err++;
        out_yumi = ($urandom_range(99) < yumi_pct);
        if (out_yumi) begin
          rec_count[n] = out_count; rec_tag[n] = out_tag;
          n++; held = 0;
          if (ee == 5) begin ee = 0; eb++; end else ee++;
        end else begin
          held = 1; hb = out_bank; he = out_event; hc = out_count; ht = out_tag;
        end
      end else begin
        out_yumi = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    out_yumi = 1'b0; snap_v = 1'b0;
    timeout = (n < 48);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({snap_ready, out_v} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshake: got ready=%b v=%b expected ready=1 v=0", snap_ready, out_v);
    end
    tests_run++;
    if ({out_bank, out_event, out_count, out_tag} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got bank=%0d ev=%0d cnt=%0d tag=%h expected all 0",
               out_bank, out_event, out_count, out_tag);
    end
    tests_run++;
    if ({s_ready, s_out_v, s_count} !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL reset_sat: got ready=%b v=%b cnt=%0d expected 1 0 0", s_ready, s_out_v, s_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_drain();
    int n, oe, he; bit to;
    applyStimulus(0, 1, 1, 1, 0, 1, 0, 1);
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 2);
    applyStimulus(0, 1, 1, 0, 1, 0, 0, 2);
    take_snapshot(32'hA5, 1'b0);
    drain(100, -1, n, oe, he, to);
    exp_cnt = '{default: 32'd0};
    exp_cnt[0] = 3; exp_cnt[1] = 2; exp_cnt[2] = 1;
    tests_run++;
    if (to || oe != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_stream: got records=%0d order_errs=%0d expected 48 and 0", n, oe);
    end
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (rec_count[i] !== exp_cnt[i] || rec_tag[i] !== 32'hA5) begin
        tests_failed++;
        $display("[TB] FAIL basic_rec%0d: got cnt=%0d tag=%h expected cnt=%0d tag=a5",
                 i, rec_count[i], rec_tag[i], exp_cnt[i]);
      end
    end
    tests_run++;
    if ({snap_ready, out_v} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL basic_ready: got ready=%b v=%b expected 1 0", snap_ready, out_v);
    end
  endtask

  task automatic test_stall();
    int n, oe, he; bit to;
    pulse_clear();
    applyStimulus(2, 1, 0, 1, 0, 0, 0, 10);
    take_snapshot(32'h22, 1'b0);
    drain(100, -1, n, oe, he, to);
    exp_cnt = '{default: 32'd0};
    exp_cnt[17] = 10;
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("[TB] FAIL stall_stream: got records=%0d expected 48", n);
    end
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (rec_count[i] !== exp_cnt[i]) begin
        tests_failed++;
        $display("[TB] FAIL stall_rec%0d: got %0d expected %0d", i, rec_count[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] srec [12];
    int n, cycles;
    s_v = 2'b10; s_yumi = 2'b10; s_ld = 2'b10;
    repeat (20) begin @(posedge clk); #1; end
    s_v = '0; s_yumi = '0; s_ld = '0;
    s_snap_v = 1'b1; s_tag = 8'h3C;
    @(posedge clk); #1;
    s_snap_v = 1'b0;
    n = 0; cycles = 0;
    while (n < 12 && cycles < 100) begin
      s_out_yumi = s_out_v;
      if (s_out_v) begin srec[n] = s_count; n++; end
      @(posedge clk); #1;
      cycles++;
    end
    s_out_yumi = 1'b0;
    tests_run++;
    if (n != 12) begin
      tests_failed++;
      $display("[TB] FAIL sat_stream: got records=%0d expected 12", n);
    end else begin
      tests_run++;
      if (srec[6] !== 4'd15) begin
        tests_failed++;
        $display("[TB] FAIL sat_ld: got %0d expected 15", srec[6]);
      end
      tests_run++;
      if (srec[0] !== 4'd0 || srec[7] !== 4'd0 || srec[11] !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL sat_others: got %0d %0d %0d expected 0 0 0", srec[0], srec[7], srec[11]);
      end
    end
    tests_run++;
    if (s_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sat_ready: got %b expected 1", s_ready);
    end
  endtask

  task automatic test_snap_clear();
    int n, oe, he; bit to;
    pulse_clear();
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 5);
    take_snapshot(32'h51, 1'b1);
    drain(100, -1, n, oe, he, to);
    tests_run++;
    if (to || rec_count[0] !== 32'd5 || rec_tag[0] !== 32'h51) begin
      tests_failed++;
      $display("[TB] FAIL snapclr_first: got ld=%0d tag=%h expected ld=5 tag=51", rec_count[0], rec_tag[0]);
    end
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 2);
    take_snapshot(32'h52, 1'b0);
    drain(100, -1, n, oe, he, to);
    tests_run++;
    if (to || rec_count[0] !== 32'd2 || rec_count[1] !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL snapclr_second: got ld=%0d st=%0d expected ld=2 st=0", rec_count[0], rec_count[1]);
    end
  endtask

  task automatic test_back_to_back();
    int n, oe, he; bit to;
    pulse_clear();
    applyStimulus(3, 1, 1, 0, 0, 0, 1, 4);
    applyStimulus(5, 1, 1, 0, 1, 1, 0, 1);
    take_snapshot(32'h1234, 1'b0);
    drain(50, 10, n, oe, he, to);
    exp_cnt = '{default: 32'd0};
    exp_cnt[22] = 4; exp_cnt[31] = 1; exp_cnt[33] = 1;
    tests_run++;
    if (to || oe != 0 || he != 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_stream: got records=%0d order_errs=%0d hold_errs=%0d expected 48 0 0", n, oe, he);
    end
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (rec_count[i] !== exp_cnt[i] || rec_tag[i] !== 32'h1234) begin
        tests_failed++;
        $display("[TB] FAIL bp_rec%0d: got cnt=%0d tag=%h expected cnt=%0d tag=1234",
                 i, rec_count[i], rec_tag[i], exp_cnt[i]);
      end
    end
    repeat (5) begin @(posedge clk); #1; end
    tests_run++;
    if ({snap_ready, out_v} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL bp_single_drain: got ready=%b v=%b expected 1 0", snap_ready, out_v);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n, oe, he; bit to;
    pulse_clear();
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 2);
    take_snapshot(32'h66, 1'b0);
    out_yumi = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    out_yumi = 1'b0;
    tests_run++;
    if (out_v !== 1'b1 || out_event !== 3'd3) begin
      tests_failed++;
      $display("[TB] FAIL midrst_pre: got v=%b ev=%0d expected 1 3", out_v, out_event);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({out_v, snap_ready, out_event, out_tag} !== {2'b01, 3'd0, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL midrst_async: got v=%b ready=%b ev=%0d tag=%h expected 0 1 0 0",
               out_v, snap_ready, out_event, out_tag);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (snap_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_ready: got %b expected 1", snap_ready);
    end
    take_snapshot(32'h77, 1'b0);
    drain(100, -1, n, oe, he, to);
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("[TB] FAIL midrst_stream: got records=%0d expected 48", n);
    end
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (rec_count[i] !== 32'd0 || rec_tag[i] !== 32'h77) begin
        tests_failed++;
        $display("[TB] FAIL midrst_rec%0d: got cnt=%0d tag=%h expected 0 77", i, rec_count[i], rec_tag[i]);
      end
    end
  endtask

  initial begin
    v = '0; yumi = '0; miss = '0; ld = '0; st = '0; at = '0;
    clear = 1'b0; snap_v = 1'b0; snap_tag = '0; out_yumi = 1'b0;
    s_v = '0; s_yumi = '0; s_miss = '0; s_ld = '0; s_st = '0; s_at = '0;
    s_clear = 1'b0; s_snap_v = 1'b0; s_tag = '0; s_out_yumi = 1'b0;
    test_reset();
    test_basic_drain();
    test_stall();
    test_saturation();
    test_snap_clear();
    test_back_to_back();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
